cpu_alu: RTL and testbench

- Single-cycle registered 32-bit integer ALU for the Flare32 CPU execute stage.
- Accepts two operands, a 4-bit operation code and the current flags.
- Produces the result and updated Z/C/V/N flags one clock later.
- Feeds the CPU write-back path and the flags special register.

---
 rtl/cpu_alu_pkg.sv | 30 +++
 rtl/cpu_alu_shifter.sv | 78 +++++++
 rtl/cpu_alu.sv | 121 ++++++++++++
 tb/tb_cpu_alu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: operation encoding, flag bit positions and datapath width.
package pkg_cpu_alu;

    localparam int unsigned ALU_WIDTH = 32;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_RSB = 4'd4,
        OP_MUL = 4'd5,
        OP_AND = 4'd6,
        OP_ORR = 4'd7,
        OP_XOR = 4'd8,
        OP_BIC = 4'd9,
        OP_LSL = 4'd10,
        OP_LSR = 4'd11,
        OP_ASR = 4'd12,
        OP_ROL = 4'd13,
        OP_ROR = 4'd14,
        OP_CPY = 4'd15
    } AluOper;

endpackage

// File: rtl/cpu_alu_shifter.sv
// Combinational barrel shifter/rotator producing the shifted value and shifter carry.
module cpu_alu_shifter
    import pkg_cpu_alu::*;
(
    input  logic [ALU_WIDTH-1:0] i_a,
    input  logic [ALU_WIDTH-1:0] i_b,
    input  AluOper               i_op,
    input  logic                 i_c,
    output logic [ALU_WIDTH-1:0] o_result,
    output logic                 o_c
);

    logic                 w_big;
    logic [4:0]           w_n;
    logic [ALU_WIDTH:0]   w_lsl_ext;
    logic [ALU_WIDTH:0]   w_lsr_ext;
    logic [ALU_WIDTH:0]   w_asr_ext;
    logic [ALU_WIDTH-1:0] w_rol;
    logic [ALU_WIDTH-1:0] w_ror;

    assign w_big = |i_b[ALU_WIDTH-1:5];
    assign w_n   = i_b[4:0];

    // One extra bit on the exit side of each shift captures the last bit shifted out.
    assign w_lsl_ext = {1'b0, i_a} << w_n;
    assign w_lsr_ext = {i_a, 1'b0} >> w_n;
    assign w_asr_ext = $signed({i_a, 1'b0}) >>> w_n;
    assign w_rol     = (i_a << w_n) | (i_a >> (6'd32 - {1'b0, w_n}));
    assign w_ror     = (i_a >> w_n) | (i_a << (6'd32 - {1'b0, w_n}));

    always_comb begin
        o_result = i_a;
        o_c      = i_c;
        case (i_op)
            OP_LSL: begin
                if (w_big) begin
                    o_result = '0;
                    o_c      = 1'b0;
                end else if (w_n != 5'd0) begin
                    o_result = w_lsl_ext[ALU_WIDTH-1:0];
                    o_c      = w_lsl_ext[ALU_WIDTH];
                end
            end
            OP_LSR: begin
                if (w_big) begin
                    o_result = '0;
                    o_c      = 1'b0;
                end else if (w_n != 5'd0) begin
                    o_result = w_lsr_ext[ALU_WIDTH:1];
                    o_c      = w_lsr_ext[0];
                end
            end
            OP_ASR: begin
                if (w_big) begin
                    o_result = {ALU_WIDTH{i_a[ALU_WIDTH-1]}};
                    o_c      = i_a[ALU_WIDTH-1];
                end else if (w_n != 5'd0) begin
                    o_result = w_asr_ext[ALU_WIDTH:1];
                    o_c      = w_asr_ext[0];
                end
            end
            OP_ROL: begin
                if (w_n != 5'd0) begin
                    o_result = w_rol;
                    o_c      = w_rol[0];
                end
            end
            OP_ROR: begin
                if (w_n != 5'd0) begin
                    o_result = w_ror;
                    o_c      = w_ror[ALU_WIDTH-1];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_alu.sv
// Flare32 execute-stage ALU: combinational datapath followed by one output register stage.
module cpu_alu
    import pkg_cpu_alu::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       oper,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);

    AluOper           w_op;
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;
    logic             w_add_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_add_v;
    logic [WIDTH-1:0] w_mul;
    logic [WIDTH-1:0] w_sh_result;
    logic             w_sh_c;
    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_flags;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    assign w_op = AluOper'(oper);

    // Every subtract form is x + ~y + cin, so the carry out is the ARM-style "no borrow" flag.
    always_comb begin
        w_add_x   = a;
        w_add_y   = b;
        w_add_cin = 1'b0;
        case (w_op)
            OP_ADC: w_add_cin = flags_in[FLAG_C];
            OP_SUB: begin
                w_add_y   = ~b;
                w_add_cin = 1'b1;
            end
            OP_SBC: begin
                w_add_y   = ~b;
                w_add_cin = flags_in[FLAG_C];
            end
            OP_RSB: begin
                w_add_x   = b;
                w_add_y   = ~a;
                w_add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_v = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != w_add_x[WIDTH-1]);
    assign w_mul   = a * b;

    cpu_alu_shifter u_shifter (
        .i_a      (a),
        .i_b      (b),
        .i_op     (w_op),
        .i_c      (flags_in[FLAG_C]),
        .o_result (w_sh_result),
        .o_c      (w_sh_c)
    );

    always_comb begin
        w_result = w_sum[WIDTH-1:0];
        case (w_op)
            OP_MUL:                                w_result = w_mul;
            OP_AND:                                w_result = a & b;
            OP_ORR:                                w_result = a | b;
            OP_XOR:                                w_result = a ^ b;
            OP_BIC:                                w_result = a & ~b;
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: w_result = w_sh_result;
            OP_CPY:                                w_result = b;
            default: ;
        endcase
    end

    always_comb begin
        w_flags = flags_in;
        case (w_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
                w_flags[FLAG_C] = w_sum[WIDTH];
                w_flags[FLAG_V] = w_add_v;
            end
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: w_flags[FLAG_C] = w_sh_c;
            default: ;
        endcase
        w_flags[FLAG_Z] = (w_result == '0);
        w_flags[FLAG_N] = w_result[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;
    assign flags_out = r_flags;

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: directed cases with fixed expectations plus randomized ops against a reference model.
module tb_cpu_alu;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  oper;
    logic [3:0]  flags_in;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  flags_out;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;
    logic [3:0]  last_fl  = '0;

    cpu_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .oper      (oper),
        .flags_in  (flags_in),
        .out_valid (out_valid),
        .result    (result),
        .flags_out (flags_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: 64-bit arithmetic and bit-at-a-time shifting.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x,
                                   input logic [31:0] y, input logic [3:0] fi);
        exp_t        e;
        logic [63:0] w;
        longint      s;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        ci;
        int          n;
        c  = fi[1];
        v  = fi[2];
        ci = fi[1];
        r  = x;
        case (op)
            4'd0, 4'd1: begin
                w = {32'd0, x} + {32'd0, y} + ((op == 4'd1) ? 64'(ci) : 64'd0);
                s = longint'($signed(x)) + longint'($signed(y)) + ((op == 4'd1) ? longint'(ci) : 0);
                r = w[31:0];
                c = w[32];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2, 4'd3: begin
                s = longint'($signed(x)) - longint'($signed(y)) - ((op == 4'd3) ? longint'(!ci) : 0);
                r = x - y - ((op == 4'd3) ? 32'(!ci) : 32'd0);
                c = {32'd0, x} >= ({32'd0, y} + ((op == 4'd3) ? 64'(!ci) : 64'd0));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: begin
                s = longint'($signed(y)) - longint'($signed(x));
                r = y - x;
                c = y >= x;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5: begin
                w = {32'd0, x} * {32'd0, y};
                r = w[31:0];
            end
            4'd6:  r = x & y;
            4'd7:  r = x | y;
            4'd8:  r = x ^ y;
            4'd9:  r = x & ~y;
            4'd10, 4'd11, 4'd12: begin
                if (y >= 32) begin
                    c = (op == 4'd12) ? x[31] : 1'b0;
                    r = (op == 4'd12) ? {32{x[31]}} : 32'd0;
                end else begin
                    n = int'(y);
                    for (int i = 0; i < n; i++) begin
                        if (op == 4'd10) begin
                            c = r[31];
                            r = {r[30:0], 1'b0};
                        end else begin
                            c = r[0];
                            r = {(op == 4'd12) ? r[31] : 1'b0, r[31:1]};
                        end
                    end
                end
            end
            4'd13, 4'd14: begin
                n = int'(y & 32'd31);
                for (int i = 0; i < n; i++) begin
                    if (op == 4'd13) begin
                        r = {r[30:0], r[31]};
                        c = r[0];
                    end else begin
                        r = {r[0], r[31:1]};
                        c = r[31];
                    end
                end
            end
            default: r = y;
        endcase
        e.res = r;
        e.fl  = {r[31], v, c, (r == 32'd0)};
        return e;
    endfunction

    // Drive one cycle, push the expectation, then sample #1 after the edge and pop/compare.
    task automatic step(input logic v, input logic r, input logic [3:0] op,
                        input logic [31:0] x, input logic [31:0] y, input logic [3:0] fi,
                        input logic use_const, input logic [31:0] c_res, input logic [3:0] c_fl);
        exp_t e;
        rst      = r;
        in_valid = v;
        oper     = op;
        a        = x;
        b        = y;
        flags_in = fi;
        if (v && !r) begin
            if (use_const) begin
                e.res = c_res;
                e.fl  = c_fl;
            end else begin
                e = model(op, x, y, fi);
            end
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(v && !r));
        if (r) begin
            sb_q.delete();
            last_res = '0;
            last_fl  = '0;
            check_eq("rst_result", result, 32'd0);
            check_eq("rst_flags", 32'(flags_out), 32'd0);
        end else if (v) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq($sformatf("result op%0d", op), result, e.res);
                check_eq($sformatf("flags op%0d", op), 32'(flags_out), 32'(e.fl));
                last_res = e.res;
                last_fl  = e.fl;
            end
        end else begin
            check_eq("hold_result", result, last_res);
            check_eq("hold_flags", 32'(flags_out), 32'(last_fl));
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        rst = 1'b1; in_valid = 1'b0; oper = '0; a = '0; b = '0; flags_in = '0;
        step(1'b0, 1'b1, 4'd0, '0, '0, 4'h0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 4'd0, 32'd1, 32'd1, 4'h0, 1'b0, '0, '0);

        // Directed cases issued back to back; flags order is {N,V,C,Z}.
        step(1'b1, 1'b0, 4'd0,  32'hFFFFFFFF, 32'd1,  4'h0, 1'b1, 32'h00000000, 4'b0011);
        step(1'b1, 1'b0, 4'd0,  32'h7FFFFFFF, 32'd1,  4'h0, 1'b1, 32'h80000000, 4'b1100);
        step(1'b1, 1'b0, 4'd2,  32'd3,        32'd5,  4'h0, 1'b1, 32'hFFFFFFFE, 4'b1000);
        step(1'b1, 1'b0, 4'd3,  32'd5,        32'd3,  4'h0, 1'b1, 32'h00000001, 4'b0010);
        step(1'b1, 1'b0, 4'd10, 32'h80000001, 32'd1,  4'h0, 1'b1, 32'h00000002, 4'b0010);
        step(1'b1, 1'b0, 4'd12, 32'h80000000, 32'd40, 4'h0, 1'b1, 32'hFFFFFFFF, 4'b1010);
        step(1'b1, 1'b0, 4'd14, 32'd1,        32'd0,  4'h2, 1'b1, 32'h00000001, 4'b0010);
        step(1'b1, 1'b0, 4'd5,  32'h00010000, 32'h00010000, 4'h6, 1'b1, 32'h00000000, 4'b0111);
        step(1'b1, 1'b0, 4'd4,  32'd7,        32'd2,  4'h0, 1'b1, 32'hFFFFFFFB, 4'b1000);
        step(1'b1, 1'b0, 4'd11, 32'h80000000, 32'd32, 4'h2, 1'b1, 32'h00000000, 4'b0001);
        step(1'b1, 1'b0, 4'd13, 32'h80000000, 32'd33, 4'h0, 1'b1, 32'h00000001, 4'b0010);

        // Idle gap: outputs must hold.
        step(1'b0, 1'b0, 4'd7, 32'h12345678, 32'h1, 4'h0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 4'd8, 32'hDEADBEEF, 32'h2, 4'hF, 1'b0, '0, '0);

        // Reset while an op is presented discards it.
        step(1'b1, 1'b1, 4'd7, 32'h12345678, 32'h1, 4'h0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'h0, 1'b0, '0, '0);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            if (op >= 4'd10 && op <= 4'd14 && $urandom_range(0, 3) != 0)
                y = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0)
                x = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
            step(($urandom_range(0, 5) != 0), 1'b0, op, x, y, 4'($urandom_range(0, 15)), 1'b0, '0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
